// File: rtl/core_pkg.sv
// Shared definitions for the layer sequencer: instruction bit map, FSM encoding
// and the wrapping SRAM address helper.
package core_pkg;

    localparam int INST_W = 35;
    localparam int ADDR_W = 11;
    localparam int CNT_W  = 16;

    localparam int INST_RSV      = 34;
    localparam int INST_ACC      = 33;
    localparam int INST_CEN_P    = 32;
    localparam int INST_WEN_P    = 31;
    localparam int INST_A_P      = 20;
    localparam int INST_CEN_X    = 19;
    localparam int INST_WEN_X    = 18;
    localparam int INST_A_X      = 7;
    localparam int INST_OFIFO_RD = 6;
    localparam int INST_IFIFO_WR = 5;
    localparam int INST_IFIFO_RD = 4;
    localparam int INST_L0_RD    = 3;
    localparam int INST_L0_WR    = 2;
    localparam int INST_EXECUTE  = 1;
    localparam int INST_LOAD     = 0;

    // Both SRAMs deselected and in read mode; everything else quiet.
    localparam logic [INST_W-1:0] INST_IDLE = (INST_W'(1) << INST_CEN_P)
                                            | (INST_W'(1) << INST_WEN_P)
                                            | (INST_W'(1) << INST_CEN_X)
                                            | (INST_W'(1) << INST_WEN_X);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WLD  = 3'd1,
        ST_KLD  = 3'd2,
        ST_KGAP = 3'd3,
        ST_ALD  = 3'd4,
        ST_EXE  = 3'd5,
        ST_DRN  = 3'd6,
        ST_DONE = 3'd7
    } state_e;

    // base + idx*stride + off, wrapped to the SRAM address width.
    function automatic logic [ADDR_W-1:0] addr_calc(input int unsigned base,
                                                    input int unsigned idx,
                                                    input int unsigned stride,
                                                    input int unsigned off);
        return ADDR_W'(base + idx * stride + off);
    endfunction

endpackage

// File: rtl/ctrl_cnt.sv
// Loadable up-counter with terminal-count compare; exposes both the registered
// count and the value it will take after the next edge.
module ctrl_cnt
    import core_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_nxt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;
    assign tc_o      = (cnt_q == term_i);

endmodule

// File: rtl/core_ctrl.sv
// Layer sequencer: for every kernel position it loads weights, pushes them into
// the PE array, streams activations, executes, and drains psums into pmem.
module core_ctrl
    import core_pkg::*;
#(
    parameter int unsigned ROW     = 8,
    parameter int unsigned COL     = 8,
    parameter int unsigned LEN_KIJ = 9,
    parameter int unsigned LEN_NIJ = 36,
    parameter int unsigned A_BASE  = 0,
    parameter int unsigned W_BASE  = 1024,
    parameter int unsigned P_BASE  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic [3:0]        kij
);

    localparam logic [CNT_W-1:0] COL_C    = CNT_W'(COL);
    localparam logic [CNT_W-1:0] NIJ_C    = CNT_W'(LEN_NIJ);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(ROW + COL - 1);
    localparam logic [3:0]       KIJ_LAST = 4'(LEN_KIJ - 1);

    state_e            state_q, state_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        kij_q, kij_d;

    logic [CNT_W-1:0]  ph_term, ph_q, ph_nxt;
    logic              ph_ld, ph_inc, ph_tc;
    logic [CNT_W-1:0]  drn_q, drn_nxt;
    logic              drn_ld, drn_tc;
    logic              rd_issue, wr_issue;
    logic              unused_cnt_bits;

    // Phase counter: position within the current state, cleared on every transition.
    assign ph_ld  = (state_d != state_q);
    assign ph_inc = (state_q != ST_IDLE);

    always_comb begin
        ph_term = '0;
        unique case (state_q)
            ST_WLD:  ph_term = COL_C;
            ST_KLD:  ph_term = COL_C - CNT_W'(1);
            ST_KGAP: ph_term = GAP_LAST;
            ST_ALD:  ph_term = NIJ_C;
            ST_EXE:  ph_term = NIJ_C - CNT_W'(1);
            default: ph_term = '0;
        endcase
    end

    ctrl_cnt #(.W(CNT_W)) u_phase_cnt (
        .clk_i     (clk),
        .rst_ni    (reset),
        .ld_i      (ph_ld),
        .ld_val_i  ('0),
        .inc_i     (ph_inc),
        .term_i    (ph_term),
        .cnt_o     (ph_q),
        .cnt_nxt_o (ph_nxt),
        .tc_o      (ph_tc)
    );

    // Drain counter tracks ofifo reads; write n always trails read n by one cycle.
    assign drn_ld   = (state_q != ST_DRN);
    assign rd_issue = (state_q == ST_DRN) && ofifo_valid && !drn_tc;
    assign wr_issue = (state_q == ST_DRN) && inst_q[INST_OFIFO_RD];

    ctrl_cnt #(.W(CNT_W)) u_drain_cnt (
        .clk_i     (clk),
        .rst_ni    (reset),
        .ld_i      (drn_ld),
        .ld_val_i  ('0),
        .inc_i     (rd_issue),
        .term_i    (NIJ_C),
        .cnt_o     (drn_q),
        .cnt_nxt_o (drn_nxt),
        .tc_o      (drn_tc)
    );

    assign unused_cnt_bits = ^{ph_q, drn_nxt};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kij_d   = kij_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WLD;
                    kij_d   = '0;
                end
            end
            ST_WLD:  if (ph_tc) state_d = ST_KLD;
            ST_KLD:  if (ph_tc) state_d = ST_KGAP;
            ST_KGAP: if (ph_tc) state_d = ST_ALD;
            ST_ALD:  if (ph_tc) state_d = ST_EXE;
            ST_EXE:  if (ph_tc) state_d = ST_DRN;
            ST_DRN: begin
                // All reads issued and none pending: this cycle carries the last write.
                if (drn_tc && !inst_q[INST_OFIFO_RD]) begin
                    if (kij_q < KIJ_LAST) begin
                        kij_d   = kij_q + 4'd1;
                        state_d = ST_WLD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so every inst bit leaves a flop
    // in the same cycle the FSM enters the corresponding phase position.
    always_comb begin
        inst_d = INST_IDLE;
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
        unique case (state_d)
            ST_WLD: begin
                if (ph_nxt < COL_C) begin
                    inst_d[INST_CEN_X] = 1'b0;
                    inst_d[INST_A_X +: ADDR_W] = addr_calc(W_BASE, 32'(kij_d), COL, 32'(ph_nxt));
                end
                if (ph_nxt != '0) begin
                    inst_d[INST_L0_WR] = 1'b1;
                end
            end
            ST_KLD: begin
                inst_d[INST_LOAD]  = 1'b1;
                inst_d[INST_L0_RD] = 1'b1;
            end
            ST_ALD: begin
                if (ph_nxt < NIJ_C) begin
                    inst_d[INST_CEN_X] = 1'b0;
                    inst_d[INST_A_X +: ADDR_W] = addr_calc(A_BASE, 0, 0, 32'(ph_nxt));
                end
                if (ph_nxt != '0) begin
                    inst_d[INST_L0_WR] = 1'b1;
                end
            end
            ST_EXE: begin
                inst_d[INST_EXECUTE] = 1'b1;
                inst_d[INST_L0_RD]   = 1'b1;
            end
            ST_DRN: begin
                inst_d[INST_OFIFO_RD] = rd_issue;
                if (wr_issue) begin
                    inst_d[INST_CEN_P] = 1'b0;
                    inst_d[INST_WEN_P] = 1'b0;
                    inst_d[INST_A_P +: ADDR_W] =
                        addr_calc(P_BASE, 32'(kij_q), LEN_NIJ, 32'(drn_q)) - ADDR_W'(1);
                end
            end
            default: ;
        endcase
        // Accumulation and input-FIFO traffic are driven by other stages.
        inst_d[INST_RSV]      = 1'b0;
        inst_d[INST_ACC]      = 1'b0;
        inst_d[INST_IFIFO_WR] = 1'b0;
        inst_d[INST_IFIFO_RD] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_q <= INST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            kij_q  <= '0;
        end else begin
            inst_q <= inst_d;
            busy_q <= busy_d;
            done_q <= done_d;
            kij_q  <= kij_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;
    assign kij  = kij_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: drives start/ofifo_valid and checks the inst
// stream, kij, busy and done against hand-computed cycle positions.
module tb_core_ctrl;

    localparam logic [34:0] INST_IDLE = 35'h1800C0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [34:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .kij         (kij)
    );

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        ofifo_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Leaves the bench at the falling edge inside cycle 1 (first cycle after start).
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        ofifo_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (inst !== INST_IDLE) begin
            errors++; $display("FAIL reset_inst: got %h, want %h", inst, INST_IDLE);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b, want 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b, want 0", done);
        end
        checks++;
        if (kij !== 4'd0) begin
            errors++; $display("FAIL reset_kij: got %0d, want 0", kij);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (inst !== INST_IDLE || busy !== 1'b0) begin
            errors++; $display("FAIL idle_hold: inst=%h busy=%b, want %h/0", inst, busy, INST_IDLE);
        end
        ofifo_valid = 1'b0;
    endtask

    task automatic test_wld_first();
        apply_reset();
        pulse_start();
        checks++;
        if (inst[19] !== 1'b0 || inst[18] !== 1'b1 || inst[17:7] !== 11'd1024) begin
            errors++; $display("FAIL wld_c1_read: CEN=%b WEN=%b A=%0d, want 0/1/1024", inst[19], inst[18], inst[17:7]);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL wld_c1_busy: got %b, want 1", busy);
        end
        checks++;
        if (inst[2] !== 1'b0) begin
            errors++; $display("FAIL wld_c1_l0wr: got %b, want 0", inst[2]);
        end
        for (int c = 2; c <= 9; c++) begin
            @(negedge clk);
            checks++;
            if (inst[2] !== 1'b1) begin
                errors++; $display("FAIL wld_l0wr cycle %0d: got %b, want 1", c, inst[2]);
            end
            checks++;
            if (c <= 8) begin
                if (inst[19] !== 1'b0 || inst[17:7] !== 11'(1024 + c - 1)) begin
                    errors++; $display("FAIL wld_read cycle %0d: CEN=%b A=%0d, want 0/%0d", c, inst[19], inst[17:7], 1024 + c - 1);
                end
            end else if (inst[19] !== 1'b1) begin
                errors++; $display("FAIL wld_last_no_read: CEN=%b, want 1", inst[19]);
            end
        end
        @(negedge clk);
        checks++;
        if (inst[0] !== 1'b1 || inst[3] !== 1'b1 || inst[2] !== 1'b0) begin
            errors++; $display("FAIL kld_first: load=%b l0_rd=%b l0_wr=%b, want 1/1/0", inst[0], inst[3], inst[2]);
        end
    endtask

    task automatic test_full_run();
        int nwr, ndone, done_cyc, max_kij, bad_fixed;
        logic prev_rd;
        logic [10:0] last_addr, k1_addr;
        bit seen_k1;
        nwr = 0; ndone = 0; done_cyc = -1; max_kij = 0; bad_fixed = 0;
        prev_rd = 1'b0; last_addr = '0; k1_addr = '0; seen_k1 = 1'b0;
        apply_reset();
        ofifo_valid = 1'b1;
        pulse_start();
        for (int cyc = 1; cyc <= 1300; cyc++) begin
            if (inst[34] !== 1'b0 || inst[33] !== 1'b0) bad_fixed++;
            if (inst[32] === 1'b0) begin
                checks++;
                if (prev_rd !== 1'b1 || inst[31] !== 1'b0) begin
                    errors++; $display("FAIL full_wr_after_rd cycle %0d: prev_rd=%b WEN=%b, want 1/0", cyc, prev_rd, inst[31]);
                end
                checks++;
                if (inst[30:20] !== 11'(nwr)) begin
                    errors++; $display("FAIL full_pmem_addr cycle %0d: got %0d, want %0d", cyc, inst[30:20], nwr);
                end
                checks++;
                if (int'(kij) != nwr / 36) begin
                    errors++; $display("FAIL full_kij write %0d: got %0d, want %0d", nwr, kij, nwr / 36);
                end
                last_addr = inst[30:20];
                nwr++;
            end
            if (!seen_k1 && kij == 4'd1 && inst[19] == 1'b0) begin
                seen_k1 = 1'b1;
                k1_addr = inst[17:7];
            end
            if (int'(kij) > max_kij) max_kij = int'(kij);
            if (done === 1'b1) begin
                ndone++;
                done_cyc = cyc;
            end
            prev_rd = inst[6];
            @(negedge clk);
        end
        checks++;
        if (nwr != 324) begin
            errors++; $display("FAIL full_write_count: got %0d, want 324", nwr);
        end
        checks++;
        if (last_addr !== 11'd323) begin
            errors++; $display("FAIL full_last_addr: got %0d, want 323", last_addr);
        end
        checks++;
        if (ndone != 1 || done_cyc != 1297) begin
            errors++; $display("FAIL full_done: pulses=%0d at cycle %0d, want 1 at 1297", ndone, done_cyc);
        end
        checks++;
        if (max_kij != 8) begin
            errors++; $display("FAIL full_max_kij: got %0d, want 8", max_kij);
        end
        checks++;
        if (!seen_k1 || k1_addr !== 11'd1032) begin
            errors++; $display("FAIL kij1_first_addr: seen=%b got %0d, want 1032", seen_k1, k1_addr);
        end
        checks++;
        if (bad_fixed != 0) begin
            errors++; $display("FAIL acc_rsv_zero: %0d cycles with acc/reserved set, want 0", bad_fixed);
        end
        checks++;
        if (busy !== 1'b0 || inst !== INST_IDLE) begin
            errors++; $display("FAIL full_end_idle: busy=%b inst=%h, want 0/%h", busy, inst, INST_IDLE);
        end
    endtask

    task automatic test_drain_toggle();
        int nwr, nrd, early_rd, cyc;
        logic prev_rd, vld_prev;
        bit reached;
        nwr = 0; nrd = 0; early_rd = 0; cyc = 1;
        prev_rd = 1'b0; reached = 1'b0;
        apply_reset();
        ofifo_valid = 1'b0;
        pulse_start();
        vld_prev = 1'b0;
        while (cyc <= 400 && !reached) begin
            if (kij == 4'd1) begin
                reached = 1'b1;
            end else begin
                if (inst[6] === 1'b1) begin
                    nrd++;
                    if (cyc < 108) early_rd++;
                    checks++;
                    if (vld_prev !== 1'b1) begin
                        errors++; $display("FAIL drn_rd_needs_valid cycle %0d: valid before=%b, want 1", cyc, vld_prev);
                    end
                end
                if (inst[32] === 1'b0) begin
                    checks++;
                    if (prev_rd !== 1'b1 || inst[31] !== 1'b0) begin
                        errors++; $display("FAIL drn_wr_after_rd cycle %0d: prev_rd=%b WEN=%b, want 1/0", cyc, prev_rd, inst[31]);
                    end
                    checks++;
                    if (inst[30:20] !== 11'(nwr)) begin
                        errors++; $display("FAIL drn_pmem_addr cycle %0d: got %0d, want %0d", cyc, inst[30:20], nwr);
                    end
                    nwr++;
                end
                prev_rd = inst[6];
                ofifo_valid = ~ofifo_valid;
                vld_prev = ofifo_valid;
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (!reached) begin
            errors++; $display("FAIL drn_toggle_exit: kij=%0d after %0d cycles, want 1", kij, cyc);
        end
        checks++;
        if (nrd != 36 || nwr != 36) begin
            errors++; $display("FAIL drn_toggle_counts: reads=%0d writes=%0d, want 36/36", nrd, nwr);
        end
        checks++;
        if (early_rd != 0) begin
            errors++; $display("FAIL ofifo_ignored_outside_drn: %0d early reads, want 0", early_rd);
        end
    endtask

    task automatic test_reset_mid_exe();
        bit found;
        found = 1'b0;
        apply_reset();
        ofifo_valid = 1'b1;
        pulse_start();
        for (int c = 0; c < 1000 && !found; c++) begin
            if (kij == 4'd3 && inst[1] == 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL mid_reach_exe: kij=%0d execute=%b, want 3/1", kij, inst[1]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (inst !== INST_IDLE) begin
            errors++; $display("FAIL mid_reset_inst: got %h, want %h", inst, INST_IDLE);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || kij !== 4'd0) begin
            errors++; $display("FAIL mid_reset_ctrl: busy=%b done=%b kij=%0d, want 0/0/0", busy, done, kij);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (inst !== INST_IDLE) begin
                errors++; $display("FAIL mid_reset_hold: got %h, want %h", inst, INST_IDLE);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        pulse_start();
        checks++;
        if (inst[19] !== 1'b0 || inst[17:7] !== 11'd1024 || kij !== 4'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL restart_wld: CEN=%b A=%0d kij=%0d busy=%b, want 0/1024/0/1", inst[19], inst[17:7], kij, busy);
        end
    endtask

    task automatic test_start_during_exe();
        int cyc, ndone, done_cyc, nwr;
        cyc = 1; ndone = 0; done_cyc = -1; nwr = 0;
        apply_reset();
        ofifo_valid = 1'b1;
        pulse_start();
        while (inst[1] !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 71) begin
            errors++; $display("FAIL exe_first_cycle: got %0d, want 71", cyc);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc++;
        checks++;
        if (kij !== 4'd0 || busy !== 1'b1 || inst[1] !== 1'b1 || inst[19] !== 1'b1) begin
            errors++; $display("FAIL start_in_exe_ignored: kij=%0d busy=%b exe=%b CEN=%b, want 0/1/1/1", kij, busy, inst[1], inst[19]);
        end
        while (cyc <= 1300) begin
            if (inst[32] === 1'b0) nwr++;
            if (done === 1'b1) begin
                ndone++;
                done_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (ndone != 1 || done_cyc != 1297) begin
            errors++; $display("FAIL start_exe_done: pulses=%0d at cycle %0d, want 1 at 1297", ndone, done_cyc);
        end
        checks++;
        if (nwr != 324) begin
            errors++; $display("FAIL start_exe_writes: got %0d, want 324", nwr);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        ofifo_valid = 1'b0;
        test_reset();
        test_wld_first();
        test_full_run();
        test_drain_toggle();
        test_reset_mid_exe();
        test_start_during_exe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
